// File: rtl/hazard_pkg.sv
// hazard_pkg: pipeline stage indices and hazard FSM state shared by the hazard unit
package hazard_pkg;
  localparam int IF_S = 0;
  localparam int ID_S = 1;
  localparam int EX_S = 2;
  localparam int MEM_S = 3;
  localparam int WB_S = 4;
  localparam int NSTAGE = 5;
  typedef enum logic {IDLE, DIV_BUSY} hz_state_e;
endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;
  always_comb q_d = clr ? '0 : (inc && q_q != '1) ? q_q + 1'b1 : q_q;
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline stall/flush generation with multi-cycle divide hold and perf counters
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int DIV_LATENCY = 16,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_flush,
  input  logic               hzd_exe_to_id_A,
  input  logic [NUM_SRC-1:0] hzd_mem_to_exe,
  input  logic               buffer_stall,
  input  logic               div_start,
  input  logic               cnt_clr,
  output logic [NSTAGE-1:0]  stall,
  output logic [NSTAGE-1:0]  flush,
  output logic               div_busy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);
  hz_state_e state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic pend_flush_q, pend_flush_d;
  logic load_hz, jalr_hz, busy, flush_inc;
  always_comb begin
    load_hz = |hzd_mem_to_exe;
    jalr_hz = hzd_exe_to_id_A;
    busy = state_q == DIV_BUSY;
    stall = '0;
    flush = '0;
    flush_inc = 1'b0;
    state_d = state_q;
    div_cnt_d = div_cnt_q;
    pend_flush_d = pend_flush_q;
    if (busy) begin
      stall[EX_S:IF_S] = '1;
      flush[MEM_S] = 1'b1;
      div_cnt_d = div_cnt_q == 8'd0 ? 8'd0 : div_cnt_q - 8'd1;
      pend_flush_d = pend_flush_q | branch_flush;
      state_d = div_cnt_q == 8'd0 ? IDLE : DIV_BUSY;
    end else begin
      stall[IF_S] = load_hz | jalr_hz | buffer_stall;
      stall[ID_S] = load_hz | jalr_hz;
      stall[EX_S] = load_hz;
      flush[EX_S] = jalr_hz | branch_flush | pend_flush_q;
      flush[MEM_S] = load_hz;
      flush_inc = branch_flush | pend_flush_q;
      pend_flush_d = 1'b0;
      state_d = div_start ? DIV_BUSY : IDLE;
      div_cnt_d = div_start ? 8'(DIV_LATENCY - 1) : div_cnt_q;
    end
    if (rst) begin
      stall = '0;
      flush = '0;
      flush_inc = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    div_cnt_q <= rst ? 8'd0 : div_cnt_d;
    pend_flush_q <= rst ? 1'b0 : pend_flush_d;
  end
  assign div_busy = busy & ~rst;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(stall[IF_S]), .q(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(flush_inc), .q(flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: random + directed check of hazard_ctrl_unit against a cycle-level behavioural model
module tb_hazard_ctrl_unit;
  localparam int DL = 4;
  localparam int NS = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0;
  logic rst, branch_flush, hzd_exe_to_id_A, buffer_stall, div_start, cnt_clr;
  logic [NS-1:0] hzd_mem_to_exe;
  logic [4:0] stall, flush;
  logic div_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  hazard_ctrl_unit #(.DIV_LATENCY(DL), .NUM_SRC(NS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .branch_flush(branch_flush), .hzd_exe_to_id_A(hzd_exe_to_id_A),
    .hzd_mem_to_exe(hzd_mem_to_exe), .buffer_stall(buffer_stall), .div_start(div_start),
    .cnt_clr(cnt_clr), .stall(stall), .flush(flush), .div_busy(div_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  function automatic void chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endfunction
  // model state: remaining busy cycles, deferred flush, counter values
  int m_busy = 0, m_sc = 0, m_fc = 0;
  bit m_pend = 0;
  always @(negedge clk) begin
    bit ld, jr, st0, finc;
    logic [4:0] es, ef;
    ld = |hzd_mem_to_exe;
    jr = hzd_exe_to_id_A;
    es = '0;
    ef = '0;
    if (!rst && m_busy > 0) begin
      es = 5'b00111;
      ef = 5'b01000;
    end else if (!rst) begin
      es = {2'b00, ld, ld | jr, ld | jr | buffer_stall};
      ef = {1'b0, ld, jr | branch_flush | m_pend, 2'b00};
    end
    chk("stall", int'(stall), int'(es));
    chk("flush", int'(flush), int'(ef));
    chk("div_busy", int'(div_busy), int'(!rst && m_busy > 0));
    chk("stall_cnt", int'(stall_cnt), m_sc);
    chk("flush_cnt", int'(flush_cnt), m_fc);
    st0 = es[0];
    finc = !rst && m_busy == 0 && (branch_flush || m_pend);
    if (rst) begin
      m_busy = 0; m_pend = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_sc = cnt_clr ? 0 : (st0 && m_sc < CMAX) ? m_sc + 1 : m_sc;
      m_fc = cnt_clr ? 0 : (finc && m_fc < CMAX) ? m_fc + 1 : m_fc;
      if (m_busy > 0) begin
        m_pend = m_pend | branch_flush;
        m_busy--;
      end else begin
        m_pend = 0;
        if (div_start) m_busy = DL;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
    #1;
  endtask
  task automatic zero_in();
    branch_flush = 0; hzd_exe_to_id_A = 0; hzd_mem_to_exe = '0;
    buffer_stall = 0; div_start = 0; cnt_clr = 0;
  endtask
  initial begin
    rst = 1;
    zero_in();
    buffer_stall = 1; hzd_mem_to_exe = 2'b11; branch_flush = 1;
    smp();
    chk("rst_stall", int'(stall), 0);
    chk("rst_flush", int'(flush), 0);
    tick(); rst = 0; zero_in(); cnt_clr = 1;
    smp(); chk("reset_cnt", int'(stall_cnt), 0);
    tick(); cnt_clr = 0; hzd_mem_to_exe = 2'b10;
    smp(); chk("lu_stall", int'(stall), 5'b00111); chk("lu_flush", int'(flush), 5'b01000);
    tick(); zero_in();
    smp(); chk("lu_scnt", int'(stall_cnt), 1); chk("lu_fcnt", int'(flush_cnt), 0);
    tick(); hzd_exe_to_id_A = 1; branch_flush = 1;
    smp(); chk("jalr_stall", int'(stall), 5'b00011); chk("jalr_flush", int'(flush), 5'b00100);
    tick(); zero_in();
    smp(); chk("jalr_fcnt", int'(flush_cnt), 1);
    tick(); div_start = 1;
    smp(); chk("div_c0", int'(div_busy), 0);
    tick(); div_start = 0;
    smp(); chk("div_c1", int'(div_busy), 1); chk("div_c1_st", int'(stall[2:0]), 3'b111);
    tick(); branch_flush = 1; hzd_mem_to_exe = 2'b11; hzd_exe_to_id_A = 1;
    smp(); chk("div_c2_st", int'(stall), 5'b00111); chk("div_c2_fl", int'(flush), 5'b01000);
    tick(); zero_in();
    smp(); chk("div_c3", int'(div_busy), 1);
    tick();
    smp(); chk("div_c4", int'(div_busy), 1); chk("div_c4_fcnt", int'(flush_cnt), 1);
    tick();
    smp(); chk("div_c5", int'(div_busy), 0); chk("pend_fl", int'(flush), 5'b00100);
    tick();
    smp(); chk("pend_once", int'(flush), 0); chk("pend_fcnt", int'(flush_cnt), 2);
    tick(); div_start = 1;
    tick(); div_start = 0;
    tick(); rst = 1; branch_flush = 1;
    smp(); chk("mid_rst_st", int'(stall), 0); chk("mid_rst_busy", int'(div_busy), 0);
    tick(); rst = 0; branch_flush = 0;
    smp();
    chk("post_rst_busy", int'(div_busy), 0); chk("post_rst_st", int'(stall), 0);
    chk("post_rst_sc", int'(stall_cnt), 0); chk("post_rst_fc", int'(flush_cnt), 0);
    tick(); buffer_stall = 1;
    repeat (20) tick();
    buffer_stall = 0;
    smp(); chk("sat_sc", int'(stall_cnt), 15);
    tick(); cnt_clr = 1;
    tick(); cnt_clr = 0;
    smp(); chk("clr_sc", int'(stall_cnt), 0);
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 79) == 0);
      branch_flush = ($urandom_range(0, 3) == 0);
      hzd_exe_to_id_A = ($urandom_range(0, 5) == 0);
      hzd_mem_to_exe = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      buffer_stall = ($urandom_range(0, 4) == 0);
      div_start = ($urandom_range(0, 7) == 0);
      cnt_clr = ($urandom_range(0, 40) == 0);
    end
    tick(); zero_in(); rst = 0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 16, cycles the divider occupies EXE; legal range 2..255.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of EXE source operands checked for load-use hazards.
REQ-003 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port branch_flush  in  1  BHT misprediction flush request.
REQ-007 SHALL have port hzd_exe_to_id_A  in  1  LOAD@EXE feeding JALR@ID.
REQ-008 SHALL have port hzd_mem_to_exe  in  NUM_SRC  LOAD@MEM feeding EXE operand i.
REQ-009 SHALL have port buffer_stall  in  1  compressed-instruction buffer needs one more fetch.
REQ-010 SHALL have port div_start  in  1  single-cycle pulse: a DIV/REM has entered EXE.
REQ-011 SHALL have port cnt_clr  in  1  synchronous clear of both performance counters.
REQ-012 SHALL have port stall  out  5  per-stage clock enable, bit 0=IF, 1=ID, 2=EXE, 3=MEM, 4=WB.
REQ-013 SHALL have port flush  out  5  per-stage active-high register reset, same indexing.
REQ-014 SHALL have port div_busy  out  1  high while FSM is in DIV_BUSY.
REQ-015 SHALL have port stall_cnt  out  CNT_W  cycles with stall[0] high.
REQ-016 SHALL have port flush_cnt  out  CNT_W  branch flushes applied to EXE.

Function
REQ-017 SHALL compute load_hz = OR of hzd_mem_to_exe and jalr_hz = hzd_exe_to_id_A, both combinationally.
REQ-018 SHALL, in IDLE: stall[0] = load_hz|jalr_hz|buffer_stall; stall[1] = load_hz|jalr_hz; stall[2] = load_hz; stall[4:3] = 0.
REQ-019 SHALL, in IDLE: flush[2] = jalr_hz|branch_flush|pend_flush; flush[3] = load_hz; flush[0], flush[1], flush[4] = 0.
REQ-020 SHALL have a two-state FSM, IDLE and DIV_BUSY; reset state IDLE.
REQ-021 SHALL transition IDLE->DIV_BUSY on div_start, loading div_cnt = DIV_LATENCY-1; div_start in DIV_BUSY is ignored.
REQ-022 SHALL, in DIV_BUSY, decrement div_cnt each cycle and return to IDLE the cycle after div_cnt==0, giving exactly DIV_LATENCY busy cycles.
REQ-023 SHALL, in DIV_BUSY, drive stall[2:0]=3'b111, flush[3]=1, all other flush bits 0, ignoring load_hz, jalr_hz and buffer_stall.
REQ-024 SHALL latch branch_flush asserted during DIV_BUSY into pend_flush and hold it.
REQ-025 SHALL apply pend_flush as flush[2] in the first IDLE cycle, then clear it.
REQ-026 SHALL let flush override stall: stall[i] and flush[i] both high means the register resets.
REQ-027 SHALL increment stall_cnt each cycle stall[0]==1 and flush_cnt each cycle flush[2] is caused by branch_flush or pend_flush; both saturate at all-ones.
REQ-028 SHALL give cnt_clr priority over increment; cleared counter reads 0 next cycle.
REQ-029 SHALL register only FSM state, div_cnt, pend_flush and the counters; stall/flush are combinational from inputs and state (zero latency).

Reset
REQ-030 SHALL, on rst, force FSM=IDLE, div_cnt=0, pend_flush=0, stall_cnt=0, flush_cnt=0, from the next edge, including mid-DIV_BUSY.
REQ-031 SHALL drive stall=0, flush=0 and div_busy=0 while rst is high, regardless of other inputs.

Structure
REQ-032 SHALL take stage index constants (IF..WB = 0..4) and the FSM state enum from a shared package, hazard_pkg.
REQ-033 SHALL implement each performance counter as an instance of one sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, q).

Verification
REQ-034 SHALL cover load-use: hzd_mem_to_exe=2'b10 for 1 cycle -> stall=5'b00111, flush=5'b01000, stall_cnt +1.
REQ-035 SHALL cover JALR: hzd_exe_to_id_A=1 with branch_flush=1 -> stall=5'b00011, flush=5'b00100, flush_cnt +1.
REQ-036 SHALL cover divide: div_start at cycle 10, DIV_LATENCY=4 -> div_busy high cycles 11-14, stall[2:0]=3'b111 in each, IDLE at cycle 15.
REQ-037 SHALL cover a deferred flush: branch_flush during cycle 12 of REQ-036 -> flush[2]=1 at cycle 15 only, flush_cnt +1.
REQ-038 SHALL cover reset mid-operation: rst at cycle 12 of REQ-036 -> cycle 13 IDLE, div_busy=0, counters 0.
REQ-039 SHALL cover saturation: CNT_W=4, buffer_stall held 20 cycles -> stall_cnt stops at 15; cnt_clr -> 0 next cycle.
